// File: rtl/tablet_fill_ctrl_if.sv
// Front-panel bundle between the switch inputs and the display/scan logic.
//   set_a, set_b : digit increment buttons (levels)
//   run, pause   : batch run / freeze controls
//   set_val, cur : tablets per bottle, tablets in current bottle
//   bot_num, sum : bottles completed this batch, saturating total since reset
//   result, warning, green, red, bot_done, batch_done : status lamps/strobes
// master = panel side (drives the buttons), slave = sequencer side.
interface tablet_fill_ctrl_if #(
    parameter int SUM_W = 10
);
    logic             set_a;
    logic             set_b;
    logic             run;
    logic             pause;
    logic [6:0]       set_val;
    logic [6:0]       cur;
    logic [7:0]       bot_num;
    logic [SUM_W-1:0] sum;
    logic             result;
    logic             warning;
    logic             green;
    logic             red;
    logic             bot_done;
    logic             batch_done;

    modport master (
        output set_a, set_b, run, pause,
        input  set_val, cur, bot_num, sum, result, warning,
               green, red, bot_done, batch_done
    );

    modport slave (
        input  set_a, set_b, run, pause,
        output set_val, cur, bot_num, sum, result, warning,
               green, red, bot_done, batch_done
    );
endinterface

// File: rtl/tablet_fill_ctrl.sv
// Tablet-bottling sequencer.
//   cp  : clock, rising edge
//   rst : synchronous active-high reset
//   pnl : front-panel bundle (slave side), see tablet_fill_ctrl_if
// One FSM (IDLE/FILL/PAUSE/SWAP/DONE) with a tick divider for tablet
// dispensing, a dwell counter for the bottle swap, two independent decimal
// digits for the per-bottle setting and a saturating batch total.
module tablet_fill_ctrl #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int BOT_TARGET = 18,
    parameter int SWAP_CYC   = 4,
    parameter int SUM_W      = 10
) (
    input  logic              cp,
    input  logic              rst,
    tablet_fill_ctrl_if.slave pnl
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int SW_W  = (SWAP_CYC > 1) ? $clog2(SWAP_CYC) : 1;

    typedef enum logic [2:0] {IDLE, FILL, PAUSE, SWAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       ones_q, ones_d, tens_q, tens_d;
    logic             a_q, b_q;
    logic [6:0]       set_val_q, set_val_d;
    logic [6:0]       cur_q, cur_d;
    logic [7:0]       bot_q, bot_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SW_W-1:0]  sw_q, sw_d;
    logic             bot_done_d;
    logic             result_q, warning_q, green_q, red_q, bot_done_q, batch_done_q;

    logic edge_a, edge_b, edges_ok, tick;

    assign edge_a   = pnl.set_a & ~a_q;
    assign edge_b   = pnl.set_b & ~b_q;
    assign edges_ok = (state_q == IDLE) || (state_q == PAUSE);
    assign tick     = (div_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        cur_d      = cur_q;
        bot_d      = bot_q;
        sum_d      = sum_q;
        div_d      = div_q;
        sw_d       = sw_q;
        bot_done_d = 1'b0;

        if (edges_ok && edge_a) ones_d = (ones_q == 4'd9) ? '0 : ones_q + 4'd1;
        if (edges_ok && edge_b) tens_d = (tens_q == 4'd9) ? '0 : tens_q + 4'd1;
        set_val_d = {3'b000, tens_d} * 7'd10 + {3'b000, ones_d};

        if (!pnl.run) begin
            state_d = IDLE;
            cur_d   = '0;
            bot_d   = '0;
            div_d   = '0;
            sw_d    = '0;
        end else begin
            case (state_q)
                // start check uses the registered (pre-edge) setting
                IDLE: if (!pnl.pause && set_val_q != '0) state_d = FILL;
                FILL: begin
                    if (pnl.pause) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        div_d = '0;
                        if (cur_q >= set_val_q) begin
                            state_d    = SWAP;
                            bot_d      = bot_q + 8'd1;
                            cur_d      = '0;
                            bot_done_d = 1'b1;
                        end else begin
                            cur_d = cur_q + 7'd1;
                            if (sum_q != '1) sum_d = sum_q + SUM_W'(1);
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                PAUSE: if (!pnl.pause) state_d = FILL;
                SWAP: begin
                    if (sw_q == SW_W'(SWAP_CYC - 1)) begin
                        sw_d    = '0;
                        div_d   = '0;
                        state_d = (bot_q == 8'(BOT_TARGET)) ? DONE : FILL;
                    end else begin
                        sw_d = sw_q + SW_W'(1);
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge cp) begin
        if (rst) begin
            state_q      <= IDLE;
            ones_q       <= '0;
            tens_q       <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            set_val_q    <= '0;
            cur_q        <= '0;
            bot_q        <= '0;
            sum_q        <= '0;
            div_q        <= '0;
            sw_q         <= '0;
            result_q     <= 1'b0;
            warning_q    <= 1'b0;
            green_q      <= 1'b0;
            red_q        <= 1'b1;
            bot_done_q   <= 1'b0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_q       <= ones_d;
            tens_q       <= tens_d;
            a_q          <= pnl.set_a;
            b_q          <= pnl.set_b;
            set_val_q    <= set_val_d;
            cur_q        <= cur_d;
            bot_q        <= bot_d;
            sum_q        <= sum_d;
            div_q        <= div_d;
            sw_q         <= sw_d;
            // compare flags are taken from the registered values, one cycle behind
            result_q     <= (cur_q == set_val_q) && (set_val_q != '0);
            warning_q    <= (cur_q > set_val_q);
            green_q      <= (state_d == FILL) || (state_d == SWAP);
            red_q        <= !((state_d == FILL) || (state_d == SWAP));
            bot_done_q   <= bot_done_d;
            batch_done_q <= (state_d == DONE);
        end
    end

    assign pnl.set_val    = set_val_q;
    assign pnl.cur        = cur_q;
    assign pnl.bot_num    = bot_q;
    assign pnl.sum        = sum_q;
    assign pnl.result     = result_q;
    assign pnl.warning    = warning_q;
    assign pnl.green      = green_q;
    assign pnl.red        = red_q;
    assign pnl.bot_done   = bot_done_q;
    assign pnl.batch_done = batch_done_q;
endmodule
